// File: rtl/rgb_bin_accum_pkg.sv
// ============================================================================
// Module   : bin_pkg
// Brief    : Shared types and parameter defaults for the RGB565 bin accumulator.
// Revision : 1.0
// ============================================================================
`default_nettype none

package bin_pkg;

    localparam int c_img_w_def = 640;
    localparam int c_img_h_def = 480;
    localparam int c_bin_w_def = 20;
    localparam int c_bin_h_def = 15;
    localparam int c_acc_w_def = 16;

    // Field order matches the {hi, lo} byte concatenation of an RGB565 pixel
    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT     = 3'd1,
        ST_POP      = 3'd2,
        ST_CAPTURE  = 3'd3,
        ST_ROW_DONE = 3'd4
    } state_t;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rgb_bin_accum_if.sv
// ============================================================================
// Module   : rgb_bin_accum_if
// Brief    : Byte FIFO read handshake between the accumulator and its source.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface rgb_bin_accum_if;

    logic       data_ready;
    logic       get_data;
    logic [7:0] p_data_sync;

    modport master (
        output get_data,
        input  data_ready,
        input  p_data_sync
    );

    modport slave (
        input  get_data,
        output data_ready,
        output p_data_sync
    );

endinterface

`default_nettype wire

// File: rtl/rgb_bin_accum_unpack.sv
// ============================================================================
// Module   : rgb565_unpack
// Brief    : Pairs consecutive bytes (high first) into RGB565 pixels.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rgb565_unpack
    import bin_pkg::*;
(
    input  wire        clk,
    input  wire        resetn,
    input  wire        byte_valid,
    input  wire  [7:0] byte_in,
    output logic       pixel_valid,
    output rgb565_t    pixel
);

    logic       r_phase;
    logic [7:0] r_hi;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_phase <= 1'b0;
            r_hi    <= 8'd0;
        end else if (byte_valid) begin
            r_phase <= ~r_phase;
            if (!r_phase) begin
                r_hi <= byte_in;
            end
        end
    end

    // Pixel is presented in the same cycle as its low byte
    assign pixel_valid = byte_valid & r_phase;
    assign pixel       = rgb565_t'({r_hi, byte_in});

endmodule

`default_nettype wire

// File: rtl/rgb_bin_accum.sv
// ============================================================================
// Module   : rgb_bin_accum
// Brief    : Pops RGB565 bytes, sums R/G/B per column bin into two row banks.
//            Optional BIN_GRAY_EN adds a 2R+G+2B luma-like sum (y_data).
// Revision : 1.0
// ============================================================================
`default_nettype none

module rgb_bin_accum
    import bin_pkg::*;
#(
    parameter int IMG_W = c_img_w_def,
    parameter int IMG_H = c_img_h_def,
    parameter int BIN_W = c_bin_w_def,
    parameter int BIN_H = c_bin_h_def,
    parameter int ACC_W = c_acc_w_def
) (
    input  wire                                       clk,
    input  wire                                       resetn,
    input  wire                                       start_en,
    rgb_bin_accum_if.master                           fifo,
    output logic [1:0][IMG_W/BIN_W-1:0][ACC_W-1:0]    r_data,
    output logic [1:0][IMG_W/BIN_W-1:0][ACC_W-1:0]    g_data,
    output logic [1:0][IMG_W/BIN_W-1:0][ACC_W-1:0]    b_data,
`ifdef BIN_GRAY_EN
    output logic [1:0][IMG_W/BIN_W-1:0][ACC_W+1:0]    y_data,
`endif
    output logic [cnt_w(IMG_H/BIN_H)-1:0]             row_o,
    output logic                                      bank_o,
    output logic                                      row_valid_o,
    output logic                                      frame_done_o,
    output logic                                      pxl_idle_o
);

    localparam int c_cols  = IMG_W / BIN_W;
    localparam int c_rows  = IMG_H / BIN_H;
    localparam int c_x_w   = cnt_w(IMG_W);
    localparam int c_cs_w  = cnt_w(BIN_W);
    localparam int c_col_w = cnt_w(c_cols);
    localparam int c_ys_w  = cnt_w(BIN_H);
    localparam int c_row_w = cnt_w(c_rows);

    generate
        if (IMG_W % BIN_W != 0) begin : g_chk_cols
            $error("IMG_W must be an exact multiple of BIN_W");
        end
        if (IMG_H % BIN_H != 0) begin : g_chk_rows
            $error("IMG_H must be an exact multiple of BIN_H");
        end
        if (ACC_W < 6 + $clog2(BIN_W * BIN_H)) begin : g_chk_acc
            $error("ACC_W too narrow for a full bin sum");
        end
    endgenerate

    state_t               r_state;
    logic                 r_wr_bank;
    logic [c_x_w-1:0]     r_x_cnt;
    logic [c_cs_w-1:0]    r_col_sub;
    logic [c_col_w-1:0]   r_col_idx;
    logic [c_ys_w-1:0]    r_y_sub;
    logic [c_row_w-1:0]   r_row_idx;

    logic                 w_pixel_valid;
    rgb565_t              w_pix;
    logic                 w_row_end;
    logic                 w_load;

    rgb565_unpack u_unpack (
        .clk         (clk),
        .resetn      (resetn),
        .byte_valid  (r_state == ST_CAPTURE),
        .byte_in     (fifo.p_data_sync),
        .pixel_valid (w_pixel_valid),
        .pixel       (w_pix)
    );

    assign w_row_end = (r_x_cnt == c_x_w'(IMG_W - 1)) && (r_y_sub == c_ys_w'(BIN_H - 1));
    // First pixel of each entry in a bin row overwrites, replacing a clear pass
    assign w_load    = (r_y_sub == '0) && (r_col_sub == '0);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state       <= ST_IDLE;
            fifo.get_data <= 1'b0;
            row_valid_o   <= 1'b0;
            frame_done_o  <= 1'b0;
            row_o         <= '0;
            bank_o        <= 1'b0;
            pxl_idle_o    <= 1'b1;
            r_wr_bank     <= 1'b0;
        end else begin
            fifo.get_data <= 1'b0;
            row_valid_o   <= 1'b0;
            frame_done_o  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start_en) begin
                        r_state    <= ST_WAIT;
                        pxl_idle_o <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (fifo.data_ready) begin
                        r_state       <= ST_POP;
                        fifo.get_data <= 1'b1;
                    end
                end
                ST_POP: begin
                    r_state <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    if (w_pixel_valid && w_row_end) begin
                        r_state      <= ST_ROW_DONE;
                        row_valid_o  <= 1'b1;
                        bank_o       <= r_wr_bank;
                        row_o        <= r_row_idx;
                        frame_done_o <= (r_row_idx == c_row_w'(c_rows - 1));
                    end else begin
                        r_state <= ST_WAIT;
                    end
                end
                ST_ROW_DONE: begin
                    r_wr_bank <= ~r_wr_bank;
                    // frame_done_o is only set while leaving the last row
                    if (frame_done_o) begin
                        r_state    <= ST_IDLE;
                        pxl_idle_o <= 1'b1;
                    end else begin
                        r_state <= ST_WAIT;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    pxl_idle_o <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_x_cnt   <= '0;
            r_col_sub <= '0;
            r_col_idx <= '0;
            r_y_sub   <= '0;
            r_row_idx <= '0;
        end else if (w_pixel_valid) begin
            if (r_x_cnt == c_x_w'(IMG_W - 1)) begin
                r_x_cnt   <= '0;
                r_col_sub <= '0;
                r_col_idx <= '0;
                if (r_y_sub == c_ys_w'(BIN_H - 1)) begin
                    r_y_sub   <= '0;
                    r_row_idx <= (r_row_idx == c_row_w'(c_rows - 1)) ? '0 : r_row_idx + 1'b1;
                end else begin
                    r_y_sub <= r_y_sub + 1'b1;
                end
            end else begin
                r_x_cnt <= r_x_cnt + 1'b1;
                if (r_col_sub == c_cs_w'(BIN_W - 1)) begin
                    r_col_sub <= '0;
                    r_col_idx <= r_col_idx + 1'b1;
                end else begin
                    r_col_sub <= r_col_sub + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_data <= '0;
            g_data <= '0;
            b_data <= '0;
        end else if (w_pixel_valid) begin
            if (w_load) begin
                r_data[r_wr_bank][r_col_idx] <= ACC_W'(w_pix.r);
                g_data[r_wr_bank][r_col_idx] <= ACC_W'(w_pix.g);
                b_data[r_wr_bank][r_col_idx] <= ACC_W'(w_pix.b);
            end else begin
                r_data[r_wr_bank][r_col_idx] <= r_data[r_wr_bank][r_col_idx] + ACC_W'(w_pix.r);
                g_data[r_wr_bank][r_col_idx] <= g_data[r_wr_bank][r_col_idx] + ACC_W'(w_pix.g);
                b_data[r_wr_bank][r_col_idx] <= b_data[r_wr_bank][r_col_idx] + ACC_W'(w_pix.b);
            end
        end
    end

`ifdef BIN_GRAY_EN
    logic [7:0] w_gray;

    assign w_gray = 8'({w_pix.r, 1'b0}) + 8'(w_pix.g) + 8'({w_pix.b, 1'b0});

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            y_data <= '0;
        end else if (w_pixel_valid) begin
            if (w_load) begin
                y_data[r_wr_bank][r_col_idx] <= (ACC_W + 2)'(w_gray);
            end else begin
                y_data[r_wr_bank][r_col_idx] <= y_data[r_wr_bank][r_col_idx] + (ACC_W + 2)'(w_gray);
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: doc/rgb_bin_accum.md
RGB_BIN_ACCUM -- requirements
Module: rgb_bin_accum

Interface
REQ-001 Parameters: IMG_W, default 640, pixels per line; IMG_H, default 480, lines per frame; BIN_W, default 20, pixels per bin; BIN_H, default 15, lines per bin; ACC_W, default 16, accumulator width.
REQ-002 Derived: COLS = IMG_W/BIN_W; ROWS = IMG_H/BIN_H. Elaboration error if either division is inexact, or if ACC_W < 6+$clog2(BIN_W*BIN_H).
REQ-003 clk  in  1  sole clock.
REQ-004 resetn  in  1  asynchronous active-low reset.
REQ-005 start_en  in  1  one-cycle pulse that starts one frame capture.
REQ-006 data_ready  in  1  upstream FIFO holds at least one byte.
REQ-007 get_data  out  1  one-cycle FIFO pop.
REQ-008 p_data_sync  in  8  FIFO byte, valid the cycle after get_data.
REQ-009 r_data, g_data, b_data  out  [1:0][COLS-1:0] x ACC_W  double-banked per-column channel sums.
REQ-010 row_o  out  $clog2(ROWS)  binned row index of the last completed bank.
REQ-011 bank_o  out  1  bank holding the last completed row.
REQ-012 row_valid_o  out  1  one-cycle pulse on each completed binned row.
REQ-013 frame_done_o  out  1  one-cycle pulse after row ROWS-1.
REQ-014 pxl_idle_o  out  1  high in IDLE.

Function
REQ-015 States: IDLE, WAIT, POP, CAPTURE, ROW_DONE. Transitions: IDLE->WAIT on start_en; WAIT->POP when data_ready; POP->CAPTURE always; CAPTURE->WAIT, or ->ROW_DONE on the last byte of the last line of a bin row; ROW_DONE->WAIT, or ->IDLE after row ROWS-1.
REQ-016 get_data is high only in POP, so at most one pop occurs every 2 cycles; no pop occurs in IDLE or ROW_DONE.
REQ-017 Byte pairs form RGB565 pixels: the first byte is the high byte. R = hi[7:3]; G = {hi[2:0], lo[7:5]}; B = lo[4:0].
REQ-018 The pixel x counter (0..IMG_W-1) and line y counter (0..IMG_H-1) wrap. Column bin = x/BIN_W, computed with a sub-counter, no divider.
REQ-019 On the low byte, R, G and B are each added, zero-extended, into the column entry of write bank wr_bank.
REQ-020 On the first pixel of each bin row, the column entry is loaded rather than added, so no separate clear pass exists.
REQ-021 ROW_DONE lasts exactly 1 cycle: row_valid_o=1, bank_o=wr_bank, row_o=bin row index, then wr_bank toggles. Read bank contents stay stable until that bank is rewritten two bin rows later.
REQ-022 frame_done_o pulses in the same cycle as row_valid_o for row ROWS-1.
REQ-023 start_en outside IDLE is ignored. start_en coincident with the ROW_DONE->IDLE transition is ignored.
REQ-024 Sums never saturate; REQ-002 guarantees headroom.

Reset
REQ-025 Reset values: state IDLE; get_data, row_valid_o, frame_done_o, row_o, bank_o = 0; pxl_idle_o = 1; all counters and wr_bank = 0; all bank entries = 0.
REQ-026 Reset asserted mid-frame aborts the frame immediately. No pop is issued in the reset cycle, and pending FIFO bytes are left to the upstream block.

Configuration
REQ-027 Macro BIN_GRAY_EN: when defined, adds output y_data, [1:0][COLS-1:0] x (ACC_W+2). It accumulates the per-pixel value 2R+G+2B under the same bank and timing rules. When undefined, the port and its logic are absent.

Structure
REQ-028 Package bin_pkg holds: the rgb565_t packed struct; the state enum; defaults for IMG_W, IMG_H, BIN_W, BIN_H and ACC_W.
REQ-029 One sub-module, rgb565_unpack: byte-pair assembler that emits a pixel_valid pulse with R, G and B.

Verification
REQ-030 Bench parameters IMG_W=40, IMG_H=30, BIN_W=20, BIN_H=15; every byte pair 0xFFFF -> each row: r=9300 (31x300), g=18900, b=9300; row_valid at rows 0,1; frame_done with row 1.
REQ-031 Pixel 0xF800 in the left half and 0x001F in the right half -> r[bank][0]=9300, b[bank][0]=0, r[bank][1]=0, b[bank][1]=9300.
REQ-032 data_ready toggled randomly -> sums identical to REQ-030, and get_data is never high while data_ready is low.
REQ-033 start_en pulsed mid-frame -> ignored, with no extra row_valid_o; resetn low mid-row -> all outputs at reset values, and a restarted frame yields correct sums.
REQ-034 Second row entirely 0x0000 -> bank 1 entries all 0, and bank 0 retains the row-0 sums (proves load-on-first-pixel).
REQ-035 With BIN_GRAY_EN defined and all pixels 0xFFFF -> y_data entries = 300x187 = 56100.
